fir4_chan_sched: RTL and testbench



---
 rtl/fir4_pkg.sv | 21 ++
 rtl/fir4_rr_arb.sv | 33 +++
 rtl/fir4_chan_sched.sv | 129 ++++++++++++
 tb/tb_fir4_chan_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir4_pkg.sv
// Shared defaults and types for the time-multiplexed 4-tap FIR channel scheduler.
package fir4_pkg;

  localparam int unsigned DefW   = 16;
  localparam int unsigned DefNch = 4;
  localparam int unsigned DefChW = $clog2(DefNch);

  // Four unsigned W-bit terms need two extra bits to sum without wrapping.
  function automatic int unsigned sum_width(input int unsigned w);
    return w + 2;
  endfunction

  typedef struct packed {
    logic [DefW-1:0] h0;
    logic [DefW-1:0] h1;
    logic [DefW-1:0] h2;
  } hist_t;

  typedef logic [DefChW-1:0] chid_t;

endpackage

// File: rtl/fir4_rr_arb.sv
// Combinational round-robin arbiter: first requester after i_ptr (modulo NCH) wins.
module fir4_rr_arb #(
  parameter  int unsigned NCH  = 4,
  localparam int unsigned CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic [NCH-1:0]  o_gnt,
  output logic [CH_W-1:0] o_gnt_id,
  output logic            o_any
);

  logic            w_found;
  logic [CH_W-1:0] w_idx;

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      w_idx = CH_W'((32'(i_ptr) + i) % NCH);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_id     = w_idx;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/fir4_chan_sched.sv
// Four-tap unit-coefficient FIR shared across NCH channels: round-robin input pick,
// per-channel history, operand stage and a sum/output stage under one valid/ready enable.
module fir4_chan_sched
  import fir4_pkg::*;
#(
  parameter  int unsigned W    = DefW,
  parameter  int unsigned NCH  = DefNch,
  localparam int unsigned CH_W = $clog2(NCH),
  localparam int unsigned SW   = sum_width(W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  input  logic             clr,
  input  logic [CH_W-1:0]  clr_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             busy
);

  logic [CH_W-1:0] r_ptr;
  logic [W-1:0]    r_h0 [NCH];
  logic [W-1:0]    r_h1 [NCH];
  logic [W-1:0]    r_h2 [NCH];

  logic            r_s1_valid;
  logic [W-1:0]    r_s1_x;
  logic [W-1:0]    r_s1_a;
  logic [W-1:0]    r_s1_b;
  logic [W-1:0]    r_s1_c;
  logic [CH_W-1:0] r_s1_ch;

  logic            r_out_valid;
  logic [SW-1:0]   r_out_data;
  logic [CH_W-1:0] r_out_ch;

  logic            w_en;
  logic [NCH-1:0]  w_gnt;
  logic [CH_W-1:0] w_gnt_id;
  logic            w_any;
  logic            w_acc;
  logic            w_clr_hit;
  logic [W-1:0]    w_x;
  logic [W-1:0]    w_h0;
  logic [W-1:0]    w_h1;
  logic [W-1:0]    w_h2;
  logic [SW-1:0]   w_sum;

  fir4_rr_arb #(
    .NCH(NCH)
  ) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_gnt_id(w_gnt_id),
    .o_any   (w_any)
  );

  assign w_en     = ~r_out_valid | out_ready;
  assign in_ready = (w_en && w_any && !reset) ? w_gnt : '0;
  assign w_acc    = |(in_valid & in_ready);
  assign w_x      = in_data[32'(w_gnt_id)*W +: W];

  // A clear aimed at the granted channel wins over its stored history.
  assign w_clr_hit = clr && (clr_ch == w_gnt_id);
  assign w_h0      = w_clr_hit ? '0 : r_h0[w_gnt_id];
  assign w_h1      = w_clr_hit ? '0 : r_h1[w_gnt_id];
  assign w_h2      = w_clr_hit ? '0 : r_h2[w_gnt_id];

  assign w_sum = SW'(r_s1_x) + SW'(r_s1_a) + SW'(r_s1_b) + SW'(r_s1_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= CH_W'(NCH - 1);
      for (int k = 0; k < NCH; k++) begin
        r_h0[k] <= '0;
        r_h1[k] <= '0;
        r_h2[k] <= '0;
      end
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_c      <= '0;
      r_s1_ch     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else begin
      // Clear first; the accept below overrides the same channel's entries afterwards.
      for (int k = 0; k < NCH; k++) begin
        if (clr && (clr_ch == CH_W'(k))) begin
          r_h0[k] <= '0;
          r_h1[k] <= '0;
          r_h2[k] <= '0;
        end
      end
      if (w_acc) begin
        r_h0[w_gnt_id] <= w_x;
        r_h1[w_gnt_id] <= w_h0;
        r_h2[w_gnt_id] <= w_h1;
        r_ptr          <= w_gnt_id;
      end
      if (w_en) begin
        r_s1_valid <= w_acc;
        if (w_acc) begin
          r_s1_x  <= w_x;
          r_s1_a  <= w_h0;
          r_s1_b  <= w_h1;
          r_s1_c  <= w_h2;
          r_s1_ch <= w_gnt_id;
        end
        r_out_valid <= r_s1_valid;
        r_out_data  <= w_sum;
        r_out_ch    <= r_s1_ch;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign busy      = r_s1_valid | r_out_valid;

endmodule

// File: tb/tb_fir4_chan_sched.sv
// Randomized and directed bench for fir4_chan_sched against a sum-level channel model.
module tb_fir4_chan_sched;
  import fir4_pkg::*;

  localparam int unsigned W    = DefW;
  localparam int unsigned NCH  = DefNch;
  localparam int unsigned CH_W = DefChW;
  localparam int unsigned SW   = W + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_ready;
  logic             clr;
  chid_t            clr_ch;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    out_data;
  logic [CH_W-1:0]  out_ch;
  logic             busy;

  fir4_chan_sched dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clr      (clr),
    .clr_ch   (clr_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the outputs must show after each edge.
  int            m_ptr = NCH - 1;
  hist_t         m_hist [NCH];
  bit            m_s1_v = 1'b0;
  bit            m_o_v  = 1'b0;
  logic [SW-1:0] m_s1_sum = '0;
  logic [SW-1:0] m_o_sum  = '0;
  int            m_s1_ch = 0;
  int            m_o_ch  = 0;
  logic [NCH-1:0] acc_mask = '0;

  // Stimulus control.
  int unsigned   src_q [NCH][$];
  bit [NCH-1:0]  pres = '0;
  int            rst_pend = 2;
  bit            clr_pend = 1'b0;
  int            clr_pend_ch = 0;
  int            ordy_force = 1;
  bit            gaps = 1'b0;
  bit            chk_en = 1'b0;

  logic [SW-1:0] obs_d [$];
  int            obs_c [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process and model update, once per cycle away from the active edge.
  initial begin : cmp
    logic [NCH-1:0] exp_rdy;
    logic [W-1:0]   x;
    logic [SW-1:0]  sum;
    bit             en;
    int             g;
    int             c;
    for (int k = 0; k < NCH; k++) m_hist[k] = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("out_valid", 64'(out_valid), 64'(m_o_v));
        if (m_o_v) begin
          check("out_data", 64'(out_data), 64'(m_o_sum));
          check("out_ch", 64'(out_ch), 64'(m_o_ch));
        end
        check("busy", 64'(busy), 64'(m_s1_v | m_o_v));
        en = !m_o_v || out_ready;
        g  = -1;
        for (int i = 1; i <= NCH; i++) begin
          c = (m_ptr + i) % NCH;
          if (g < 0 && in_valid[c]) g = c;
        end
        exp_rdy = '0;
        if (!reset && en && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc_mask = exp_rdy;
        if (!reset && out_valid && out_ready) begin
          obs_d.push_back(out_data);
          obs_c.push_back(int'(out_ch));
        end
        if (reset) begin
          m_ptr = NCH - 1;
          for (int k = 0; k < NCH; k++) m_hist[k] = '0;
          m_s1_v = 1'b0;
          m_o_v  = 1'b0;
          m_o_sum = '0;
          m_o_ch  = 0;
        end else begin
          sum = '0;
          if (clr) m_hist[clr_ch] = '0;
          if (exp_rdy != '0) begin
            x   = in_data[g*W +: W];
            sum = SW'(x) + SW'(m_hist[g].h0) + SW'(m_hist[g].h1) + SW'(m_hist[g].h2);
            m_hist[g] = '{h0: x, h1: m_hist[g].h0, h2: m_hist[g].h1};
            m_ptr = g;
          end
          if (en) begin
            m_o_v   = m_s1_v;
            m_o_sum = m_s1_sum;
            m_o_ch  = m_s1_ch;
            m_s1_v  = (exp_rdy != '0);
            if (exp_rdy != '0) begin
              m_s1_sum = sum;
              m_s1_ch  = g;
            end
          end
        end
      end
    end
  end

  // Sources: hold a presented sample until the model says it was accepted.
  initial begin : drv
    reset = 1'b1; in_valid = '0; in_data = '0; clr = 1'b0; clr_ch = '0; out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NCH; k++) begin
        if (acc_mask[k] && src_q[k].size() > 0) begin
          void'(src_q[k].pop_front());
          pres[k] = 1'b0;
        end
      end
      reset = (rst_pend > 0);
      if (rst_pend > 0) rst_pend--;
      clr      = clr_pend;
      clr_ch   = chid_t'(clr_pend_ch);
      clr_pend = 1'b0;
      out_ready = (ordy_force == 2) ? ($urandom_range(0, 3) != 0) : (ordy_force != 0);
      for (int k = 0; k < NCH; k++) begin
        if (src_q[k].size() == 0) pres[k] = 1'b0;
        else if (!pres[k]) pres[k] = !gaps || ($urandom_range(0, 2) != 0);
        in_valid[k] = pres[k];
        in_data[k*W +: W] = pres[k] ? W'(src_q[k][0]) : '0;
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      done = (rst_pend == 0) && !clr_pend && !m_s1_v && !m_o_v;
      for (int k = 0; k < NCH; k++) if (src_q[k].size() != 0) done = 1'b0;
    end
    if (!done) check("wait_idle timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    for (int k = 0; k < NCH; k++) src_q[k].delete();
    rst_pend = 1;
    repeat (2) @(negedge clk);
    #1;
    obs_d.delete();
    obs_c.delete();
  endtask

  task automatic check_obs(input string nm, input int n, input int unsigned ed[8],
                           input int ec[8]);
    check({nm, " count"}, 64'(obs_d.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < obs_d.size()) begin
        check({nm, " data"}, 64'(obs_d[i]), 64'(ed[i]));
        check({nm, " ch"}, 64'(obs_c[i]), 64'(ec[i]));
      end
    end
  endtask

  initial begin : test
    int unsigned ed[8];
    int          ec[8];
    logic [SW-1:0] held;

    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'(0));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset out_data", 64'(out_data), 64'(0));
    check("reset out_ch", 64'(out_ch), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    wait_idle(10);

    // Single channel back-to-back.
    do_reset();
    for (int v = 1; v <= 5; v++) src_q[0].push_back(v);
    wait_idle(50);
    ed = '{1, 3, 6, 10, 14, 0, 0, 0}; ec = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_obs("single", 5, ed, ec);

    // Round robin with all channels requesting.
    do_reset();
    for (int k = 0; k < NCH; k++) begin
      src_q[k].push_back(100 * (k + 1));
      src_q[k].push_back(100 * (k + 1));
    end
    wait_idle(50);
    ed = '{100, 200, 300, 400, 200, 400, 600, 800}; ec = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_obs("rr", 8, ed, ec);

    // Backpressure for three cycles.
    do_reset();
    for (int v = 1; v <= 6; v++) src_q[0].push_back(v);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    ordy_force = 0;
    @(negedge clk);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      check("bp out_valid", 64'(out_valid), 64'(1));
      check("bp in_ready", 64'(in_ready), 64'(0));
      check("bp busy", 64'(busy), 64'(1));
      check("bp out_data stable", 64'(out_data), 64'(held));
      check("bp out_ch", 64'(out_ch), 64'(0));
      @(negedge clk);
    end
    ordy_force = 1;
    wait_idle(50);
    ed = '{1, 3, 6, 10, 14, 18, 0, 0}; ec = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_obs("bp", 6, ed, ec);

    // Full-scale samples must not wrap.
    do_reset();
    for (int v = 0; v < 4; v++) src_q[2].push_back(32'hFFFF);
    wait_idle(50);
    ed = '{32'hFFFF, 32'h1FFFE, 32'h2FFFD, 32'h3FFFC, 0, 0, 0, 0}; ec = '{2, 2, 2, 2, 0, 0, 0, 0};
    check_obs("max", 4, ed, ec);

    // Clear coinciding with an accept, then a clear of another channel.
    do_reset();
    src_q[1].push_back(10); src_q[1].push_back(20); src_q[1].push_back(30);
    wait_idle(50);
    src_q[1].push_back(5); clr_pend = 1'b1; clr_pend_ch = 1;
    wait_idle(50);
    src_q[1].push_back(7);
    wait_idle(50);
    src_q[1].push_back(1); clr_pend = 1'b1; clr_pend_ch = 3;
    wait_idle(50);
    ed = '{10, 30, 60, 5, 12, 13, 0, 0}; ec = '{1, 1, 1, 1, 1, 1, 0, 0};
    check_obs("clr", 6, ed, ec);

    // Reset with both pipeline stages full, then a simultaneous two-channel request.
    do_reset();
    ordy_force = 0;
    src_q[0].push_back(1); src_q[0].push_back(2); src_q[0].push_back(3);
    repeat (4) @(negedge clk);
    #1;
    check("rstmid out_valid before", 64'(out_valid), 64'(1));
    check("rstmid busy before", 64'(busy), 64'(1));
    for (int k = 0; k < NCH; k++) src_q[k].delete();
    obs_d.delete(); obs_c.delete();
    rst_pend = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rstmid out_valid after", 64'(out_valid), 64'(0));
    check("rstmid busy after", 64'(busy), 64'(0));
    ordy_force = 1;
    src_q[0].push_back(9); src_q[1].push_back(9);
    wait_idle(50);
    ed = '{9, 9, 0, 0, 0, 0, 0, 0}; ec = '{0, 1, 0, 0, 0, 0, 0, 0};
    check_obs("rstmid", 2, ed, ec);

    // Randomized traffic: gaps, backpressure, clears and occasional resets.
    do_reset();
    gaps = 1'b1;
    ordy_force = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      #1;
      begin
        int k;
        k = $urandom_range(0, NCH - 1);
        if (src_q[k].size() < 3)
          src_q[k].push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF : $urandom_range(0, 65535));
      end
      if ($urandom_range(0, 11) == 0) begin
        clr_pend = 1'b1;
        clr_pend_ch = $urandom_range(0, NCH - 1);
      end
      if (rst_pend == 0 && $urandom_range(0, 299) == 0) rst_pend = 1;
    end
    ordy_force = 1;
    wait_idle(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
